spi_flash_slave: RTL
====================

# spi_flash_slave

Synthesizable SPI flash responder: the device end of the SPI link driven by `flash_ctrl`/`spi_master`. It oversamples the serial lines with the system clock and decodes READ, WREN, PP, SE and RDSR. It holds a small byte array and models WIP/WEL status with busy timers. Used as the on-chip flash stand-in for simulation and FPGA bring-up.

## Interface
- `MEM_AW`, 8: memory address width; depth is 2^MEM_AW bytes (≤16). Upper address bits are ignored, so addresses alias.
- `PP_BUSY`, 64: clk cycles WIP stays set after a page program.
- `SE_BUSY`, 256: extra clk cycles WIP stays set after the erase sweep finishes.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `CLK` in 1: SPI clock from the master (mode 0; idles low).
- `CS` in 1: chip select, active low.
- `D` in 1: master-out serial data, MSB first.
- `Q` out 1: slave-out serial data. Reset value 0. Driven 0 whenever CS is high (no tristate).
- `wip` out 1: status bit 0. Reset value 0.
- `wel` out 1: status bit 1. Reset value 0.

## Operation
- `CLK`, `CS` and `D` each pass through a 2-flop synchronizer. Edges of synced `CLK` are detected.
  - Rising edge: shift in synced `D`.
  - Falling edge: shift out the next `Q` bit.
- Synced `CS` high forces state IDLE and clears the bit and byte counters. A partial byte is discarded.
- FSM states and transitions:
  - IDLE: `CS` falls → CMD.
  - CMD: collects 8 bits, then dispatches:
    - 03 → ADDR, or IGNORE if `wip`.
    - 06 → IGNORE; sets `wel` at `CS` rise, only if not `wip`.
    - 02 / D8 → ADDR, or IGNORE if `wip` or `!wel`.
    - 05 → STATUS.
    - Any other opcode → IGNORE.
  - ADDR: collects 24 bits, then → RD_DATA, PP_DATA, or SE_WAIT according to the opcode.
  - RD_DATA: outputs mem[addr] MSB first. Advances addr at each byte end; wraps modulo 2^MEM_AW.
  - PP_DATA: at each completed byte, writes mem[{addr[MEM_AW-1:8], pg}] ← old & byte. Only the low 8 bits (`pg`) increment, wrapping inside the 256-byte page; if MEM_AW<8, `pg` is truncated to MEM_AW bits.
  - STATUS: outputs {6'b0, wel, wip} repeatedly, resampled at each byte start.
  - SE_WAIT / IGNORE: `Q`=0, input ignored.
- Execution on `CS` rising:
  - PP with ≥1 data byte: clear `wel`, set `wip`, load timer with PP_BUSY.
  - SE with all 32 bits received: clear `wel`, set `wip`, start the erase sweep.
  - A PP with 0 data bytes or a truncated SE has no effect.
- Erase sweep:
  - Writes 0xFF to one address per clk, 0 to 2^MEM_AW−1.
  - Then counts SE_BUSY cycles, then clears `wip`.
- PP timer: counts down PP_BUSY cycles, then clears `wip`.
- Memory is not affected by reset and is undefined at power-up. Testbenches erase first.
- Reset mid-operation: FSM → IDLE, `wip`=`wel`=0, timers and sweep abort, `Q`=0. Memory keeps any partially written or erased contents.

## Timing
- Master requirement: each `CLK` high and low phase ≥4 clk; `CS` high time between transactions ≥4 clk.
- Synchronizer latency is 2 clk. `Q` updates 3 clk after the falling `CLK` edge on the pins, and is stable before the next rising edge.
- First read/status data bit: driven on the falling edge that follows the last command/address rising edge.
- `wel` set/clear and `wip` set occur 3 clk after `CS` rises on the pins.
- PP: `wip` is high for exactly PP_BUSY cycles.
- SE: `wip` is high for 2^MEM_AW + SE_BUSY cycles.
- Simultaneous events:
  - A `CS` rise on the same synced cycle as a rising `CLK` edge: the `CS` rise wins and the bit is dropped.
  - A RDSR byte started the cycle `wip` clears returns the new value.

## Structure
- Shared package `spi_flash_pkg`:
  - Opcode constants 03/06/02/D8/05; these are also used by `flash_ctrl`.
  - FSM state encoding.
  - Status bit indices WIP=0, WEL=1.
- Sub-module `spi_pin_sync`: 2-flop synchronizers plus `CLK` rise/fall pulse generation. Everything else stays in `spi_flash_slave`.

## Test plan
- WREN; RDSR → 0x02; SE 0x000000; RDSR polled → 0x01 until 256+256 cycles, then 0x00; READ 0x000010 → 0xFF.
- After erase: WREN; PP 0x000005 data A5,3C; poll WIP to 0; READ 0x000004, 4 bytes → FF,A5,3C,FF.
- PP 0x000020 data 00 without WREN → READ 0x000020 = 0xFF, status 0x00, `wip` never rises.
- Page wrap: WREN; PP 0x0000FE data 11,22,33 → mem[FE]=11, mem[FF]=22, mem[00]=33.
- Busy lockout: during SE busy, READ returns `Q`=0 for all bits; WREN ignored (`wel` stays 0); RDSR = 0x01.
- Aborts:
  - `CS` rises after 5 bits of 06 → `wel` stays 0.
  - `reset` pulsed mid-erase → next cycle `wip`=0, `wel`=0, `Q`=0; a following RDSR → 0x00.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, status bit
// positions and the command FSM state encoding.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_SE   = 8'hD8;
   localparam logic [7:0] OP_RDSR = 8'h05;

   localparam int unsigned WIP_BIT = 0;
   localparam int unsigned WEL_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD_DATA,
      ST_PP_DATA,
      ST_STATUS,
      ST_SE_WAIT,
      ST_IGNORE
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins, plus SCK edge pulses and a
// chip-select rising pulse, all in the system clock domain.
module spi_pin_sync
   import spi_flash_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic sck_pin,
   input  logic cs_pin,
   input  logic d_pin,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_high,
   output logic cs_rise,
   output logic d_bit
);

   logic [2:0] sck_sr;
   logic [2:0] cs_sr;
   logic [1:0] d_sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sr <= '0;
         cs_sr  <= '1;
         d_sr   <= '0;
      end else begin
         sck_sr <= {sck_sr[1:0], sck_pin};
         cs_sr  <= {cs_sr[1:0], cs_pin};
         d_sr   <= {d_sr[0], d_pin};
      end
   end

   // Bit 1 is the synchronized level; bit 2 is only used for edge detection.
   assign sck_rise = sck_sr[1] & ~sck_sr[2];
   assign sck_fall = ~sck_sr[1] & sck_sr[2];
   assign cs_high  = cs_sr[1];
   assign cs_rise  = cs_sr[1] & ~cs_sr[2];
   assign d_bit    = d_sr[1];

endmodule

// File: rtl/spi_flash_slave.sv
// SPI flash responder: decodes READ/WREN/PP/SE/RDSR over an oversampled
// mode-0 link and models WIP/WEL with busy timers over a small byte array.
module spi_flash_slave
   import spi_flash_pkg::*;
#(
   parameter int unsigned MEM_AW  = 8,
   parameter int unsigned PP_BUSY = 64,
   parameter int unsigned SE_BUSY = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic CLK,
   input  logic CS,
   input  logic D,
   output logic Q,
   output logic wip,
   output logic wel
);

   localparam int unsigned DEPTH = 2 ** MEM_AW;

   logic sck_rise, sck_fall, cs_high, cs_rise, d_bit;

   spi_pin_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .sck_pin  (CLK),
      .cs_pin   (CS),
      .d_pin    (D),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_high  (cs_high),
      .cs_rise  (cs_rise),
      .d_bit    (d_bit)
   );

   logic [7:0]        mem [DEPTH];
   state_t            state;
   logic [2:0]        bit_cnt;
   logic [1:0]        addr_byte;
   logic [7:0]        sh_in;
   logic [7:0]        sh_out;
   logic [7:0]        opcode;
   logic [23:0]       addr;
   logic              q_reg;
   logic              wren_pend;
   logic              pp_seen;
   logic              sweep;
   logic [MEM_AW-1:0] sweep_addr;
   logic [31:0]       timer;

   logic [7:0]        byte_in;
   logic              byte_done;
   logic [MEM_AW-1:0] idx;
   logic              timer_done;
   logic [7:0]        status;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_wa;
   logic [7:0]        mem_wd;

   assign byte_in    = {sh_in[6:0], d_bit};
   assign byte_done  = sck_rise && (bit_cnt == 3'd7);
   assign idx        = addr[MEM_AW-1:0];
   assign timer_done = wip && !sweep && (timer == 32'd0);
   assign Q          = q_reg & ~CS;

   // A status byte loaded on the cycle WIP clears already reports it clear.
   always_comb begin
      status          = '0;
      status[WIP_BIT] = wip && !timer_done;
      status[WEL_BIT] = wel;
   end

   always_comb begin
      mem_we = 1'b0;
      mem_wa = idx;
      mem_wd = mem[idx] & byte_in;
      if (sweep) begin
         mem_we = !reset;
         mem_wa = sweep_addr;
         mem_wd = 8'hFF;
      end else if (!reset && !cs_high && state == ST_PP_DATA && byte_done) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         addr_byte  <= '0;
         sh_in      <= '0;
         sh_out     <= '0;
         opcode     <= '0;
         addr       <= '0;
         q_reg      <= 1'b0;
         wren_pend  <= 1'b0;
         pp_seen    <= 1'b0;
         wip        <= 1'b0;
         wel        <= 1'b0;
         sweep      <= 1'b0;
         sweep_addr <= '0;
         timer      <= '0;
      end else begin
         if (sweep) begin
            sweep_addr <= sweep_addr + 1'b1;
            if (&sweep_addr) begin
               sweep <= 1'b0;
               timer <= 32'(SE_BUSY - 1);
            end
         end else if (timer_done) begin
            wip <= 1'b0;
         end else if (wip) begin
            timer <= timer - 32'd1;
         end

         if (cs_high) begin
            // Deferred commands execute on the CS rise, using the state reached.
            if (cs_rise) begin
               if (wren_pend) wel <= 1'b1;
               if (state == ST_PP_DATA && pp_seen) begin
                  wel   <= 1'b0;
                  wip   <= 1'b1;
                  timer <= 32'(PP_BUSY - 1);
               end
               if (state == ST_SE_WAIT) begin
                  wel        <= 1'b0;
                  wip        <= 1'b1;
                  sweep      <= 1'b1;
                  sweep_addr <= '0;
               end
            end
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            addr_byte <= '0;
            q_reg     <= 1'b0;
            wren_pend <= 1'b0;
            pp_seen   <= 1'b0;
         end else if (state == ST_IDLE) begin
            state <= ST_CMD;
         end else begin
            if (sck_rise) begin
               bit_cnt <= bit_cnt + 1'b1;
               sh_in   <= byte_in;
               case (state)
                  ST_CMD: begin
                     if (byte_done) begin
                        opcode <= byte_in;
                        case (byte_in)
                           OP_READ: state <= wip ? ST_IGNORE : ST_ADDR;
                           OP_WREN: begin
                              state     <= ST_IGNORE;
                              wren_pend <= !wip;
                           end
                           OP_PP, OP_SE: state <= (wip || !wel) ? ST_IGNORE : ST_ADDR;
                           OP_RDSR: state <= ST_STATUS;
                           default: state <= ST_IGNORE;
                        endcase
                     end
                  end
                  ST_ADDR: begin
                     addr <= {addr[22:0], d_bit};
                     if (byte_done) begin
                        addr_byte <= addr_byte + 1'b1;
                        if (addr_byte == 2'd2) begin
                           case (opcode)
                              OP_READ: state <= ST_RD_DATA;
                              OP_PP:   state <= ST_PP_DATA;
                              default: state <= ST_SE_WAIT;
                           endcase
                        end
                     end
                  end
                  ST_RD_DATA: if (byte_done) addr <= addr + 24'd1;
                  ST_PP_DATA: begin
                     if (byte_done) begin
                        addr[7:0] <= addr[7:0] + 8'd1;
                        pp_seen   <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            if (sck_fall) begin
               case (state)
                  ST_RD_DATA, ST_STATUS: begin
                     if (bit_cnt == 3'd0) begin
                        q_reg  <= (state == ST_RD_DATA) ? mem[idx][7] : status[7];
                        sh_out <= (state == ST_RD_DATA) ? {mem[idx][6:0], 1'b0}
                                                        : {status[6:0], 1'b0};
                     end else begin
                        q_reg  <= sh_out[7];
                        sh_out <= {sh_out[6:0], 1'b0};
                     end
                  end
                  default: q_reg <= 1'b0;
               endcase
            end
         end
      end
   end

endmodule
